// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB master engine: FSM states,
// quarter-phase codes, byte counts and fixed transaction lengths.
package sccb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    TX_BYTE,
    RX_ACK,
    STOP,
    RESTART_STOP,
    RESTART_START,
    RX_BYTE,
    TX_NACK,
    DONE
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int WR_BYTES     = 3;
  localparam int RD_PH1_BYTES = 2;

  // Fixed transaction lengths in quarter-bit periods.
  localparam int WR_QUARTERS = 116;
  localparam int RD_QUARTERS = 160;

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-bit tick generator: pulses tick for one iCLK every QTR cycles;
// clr realigns the count so the first quarter after a start is full length.
module sccb_tick_gen #(
  parameter int QTR = 62
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic clr,
  output logic tick
);

  if (QTR < 2) begin : g_bad_qtr
    $error("sccb_tick_gen: QTR must be at least 2");
  end

  localparam int CW = (QTR < 2) ? 1 : $clog2(QTR);
  localparam logic [CW-1:0] LAST = CW'(QTR - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/sccb_master_engine.sv
// Bit-level SCCB master: START, byte shifts, ACK sampling and STOP for
// 3-byte writes and two-phase register reads, timed by quarter-bit ticks.
module sccb_master_engine
  import sccb_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int I2C_FREQ = 100_000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        GO,
  input  logic        WR,
  input  logic [23:0] WDATA,
  output logic        I2C_SCLK,
  inout  wire         I2C_SDAT,
  output logic        END,
  output logic        ACK,
  output logic        BUSY,
  output logic [7:0]  RDATA
);

  localparam int QTR = CLK_FREQ / (4 * I2C_FREQ);
  localparam logic [1:0] WR_LAST  = 2'(WR_BYTES - 1);
  localparam logic [1:0] PH1_LAST = 2'(RD_PH1_BYTES - 1);

  state_t      state;
  logic [1:0]  qtr;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_idx;
  logic [7:0]  tx_sh, rx_sh;
  logic [6:0]  slave_q;
  logic [7:0]  reg_q, data_q;
  logic        wr_q, phase2, go_d, sda_rel;
  logic        tick, start, qtr_last, sample, sda_in;
  logic        scl_nxt, sda_nxt;
  logic [7:0]  next_byte;

  // The R/W bit is generated by the engine, so WDATA[16] is never used.
  logic unused_rw_bit;
  assign unused_rw_bit = WDATA[16];

  assign start     = (state == IDLE) && GO && !go_d;
  assign qtr_last  = tick && (qtr == Q3);
  assign sample    = tick && (qtr == Q2);
  assign next_byte = (byte_idx == 2'd0) ? reg_q : data_q;

  assign I2C_SDAT = sda_rel ? 1'bz : 1'b0;
  assign sda_in   = I2C_SDAT;

  sccb_tick_gen #(.QTR(QTR)) u_tick (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .clr    (start),
    .tick   (tick)
  );

  // NOTE: both outputs get a default before the case so no path leaves them
  // unassigned, which would otherwise infer latches.
  always_comb begin
    scl_nxt = 1'b1;
    sda_nxt = 1'b1;
    case (state)
      START, RESTART_START: begin
        scl_nxt = (qtr != Q3);
        sda_nxt = (qtr == Q0);
      end
      STOP, RESTART_STOP: begin
        scl_nxt = (qtr != Q0);
        sda_nxt = qtr[1];
      end
      TX_BYTE: begin
        scl_nxt = qtr[1];
        sda_nxt = tx_sh[7];
      end
      RX_ACK, RX_BYTE, TX_NACK: scl_nxt = qtr[1];
      default: ;
    endcase
  end

  // NOTE: every register here uses <= so all updates see the pre-edge
  // values; blocking assignments would make the result order-dependent.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= IDLE;
      qtr      <= Q0;
      bit_cnt  <= 3'd0;
      byte_idx <= 2'd0;
      tx_sh    <= 8'h00;
      rx_sh    <= 8'h00;
      slave_q  <= 7'h00;
      reg_q    <= 8'h00;
      data_q   <= 8'h00;
      wr_q     <= 1'b0;
      phase2   <= 1'b0;
      go_d     <= 1'b0;
      sda_rel  <= 1'b1;
      I2C_SCLK <= 1'b1;
      END      <= 1'b1;
      BUSY     <= 1'b0;
      ACK      <= 1'b0;
      RDATA    <= 8'h00;
    end else begin
      go_d     <= GO;
      I2C_SCLK <= scl_nxt;
      sda_rel  <= sda_nxt;
      if (tick) qtr <= qtr + 2'd1;

      case (state)
        IDLE: if (start) begin
          state    <= START;
          qtr      <= Q0;
          slave_q  <= WDATA[23:17];
          reg_q    <= WDATA[15:8];
          data_q   <= WDATA[7:0];
          wr_q     <= WR;
          phase2   <= 1'b0;
          tx_sh    <= {WDATA[23:17], 1'b0};
          bit_cnt  <= 3'd7;
          byte_idx <= 2'd0;
          END      <= 1'b0;
          BUSY     <= 1'b1;
          ACK      <= 1'b0;
        end
        START, RESTART_START: if (qtr_last) state <= TX_BYTE;
        TX_BYTE: if (qtr_last) begin
          if (bit_cnt == 3'd0) begin
            state <= RX_ACK;
          end else begin
            bit_cnt <= bit_cnt - 3'd1;
            tx_sh   <= {tx_sh[6:0], 1'b0};
          end
        end
        RX_ACK: begin
          if (sample) ACK <= ACK | sda_in;
          if (qtr_last) begin
            bit_cnt  <= 3'd7;
            byte_idx <= byte_idx + 2'd1;
            if (phase2)                            state <= RX_BYTE;
            else if (wr_q && byte_idx == WR_LAST)  state <= STOP;
            else if (!wr_q && byte_idx == PH1_LAST) state <= RESTART_STOP;
            else begin
              state <= TX_BYTE;
              tx_sh <= next_byte;
            end
          end
        end
        RESTART_STOP: if (qtr_last) begin
          state   <= RESTART_START;
          phase2  <= 1'b1;
          tx_sh   <= {slave_q, 1'b1};
          bit_cnt <= 3'd7;
        end
        RX_BYTE: begin
          if (sample) rx_sh <= {rx_sh[6:0], sda_in};
          if (qtr_last) begin
            if (bit_cnt == 3'd0) state <= TX_NACK;
            else bit_cnt <= bit_cnt - 3'd1;
          end
        end
        TX_NACK: if (qtr_last) state <= STOP;
        STOP:    if (qtr_last) state <= DONE;
        DONE: begin
          state <= IDLE;
          END   <= 1'b1;
          BUSY  <= 1'b0;
          if (!wr_q) RDATA <= rx_sh;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_master_engine.sv
// Directed bench for sccb_master_engine with an SCCB slave model and a
// START/STOP monitor sampling the bus on the falling iCLK edge.
module tb_sccb_master_engine;

  logic        iCLK   = 1'b0;
  logic        iRST_N = 1'b0;
  logic        GO     = 1'b0;
  logic        WR     = 1'b0;
  logic [23:0] WDATA  = 24'h0;
  logic        I2C_SCLK, END, ACK, BUSY;
  logic [7:0]  RDATA;
  wire         I2C_SDAT;

  logic        drv_low   = 1'b0;
  logic [3:0]  nack_mask = 4'b0000;
  logic [7:0]  rd_byte   = 8'h76;

  int checks   = 0;
  int failures = 0;

  pullup (I2C_SDAT);
  assign I2C_SDAT = drv_low ? 1'b0 : 1'bz;

  sccb_master_engine #(.CLK_FREQ(800), .I2C_FREQ(100)) dut (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .GO       (GO),
    .WR       (WR),
    .WDATA    (WDATA),
    .I2C_SCLK (I2C_SCLK),
    .I2C_SDAT (I2C_SDAT),
    .END      (END),
    .ACK      (ACK),
    .BUSY     (BUSY),
    .RDATA    (RDATA)
  );

  always #5 iCLK = ~iCLK;

  // Slave model and bus monitor: an SDA change while SCL stays high is
  // counted as START/STOP; bytes and ack-slot levels are logged on SCL rise.
  int         starts = 0, stops = 0, bitn = -1, byten = 0;
  logic       scl_p = 1'b1, sda_p = 1'b1, rd_mode = 1'b0, last_ack = 1'b1;
  logic [7:0] sh = 8'h00;
  logic [7:0] bytes_q[$];
  logic       ack_q[$];

  always @(negedge iCLK) begin : slave_model
    logic scl_n, sda_n;
    scl_n = I2C_SCLK;
    sda_n = I2C_SDAT;
    if (scl_p === 1'b1 && scl_n === 1'b1 && sda_p !== sda_n) begin
      if (sda_n === 1'b0) begin
        starts++; bitn = -1; byten = 0; rd_mode = 1'b0; drv_low = 1'b0;
      end else begin
        stops++; bitn = -1; drv_low = 1'b0;
      end
    end else if (scl_p === 1'b0 && scl_n === 1'b1) begin
      if (bitn >= 0 && bitn < 8) begin
        sh = {sh[6:0], sda_n};
        if (bitn == 7) bytes_q.push_back(sh);
      end else if (bitn == 8) begin
        ack_q.push_back(sda_n);
        last_ack = sda_n;
      end
    end else if (scl_p === 1'b1 && scl_n === 1'b0) begin
      if (bitn < 0) begin
        bitn = 0;
      end else if (bitn < 7) begin
        bitn++;
        if (rd_mode && byten > 0) drv_low = !rd_byte[7-bitn];
      end else if (bitn == 7) begin
        bitn = 8;
        if (byten == 0) rd_mode = sh[0];
        drv_low = (rd_mode && byten > 0) ? 1'b0 : !nack_mask[byten];
      end else begin
        bitn = 0;
        byten++;
        drv_low = (rd_mode && !last_ack) ? !rd_byte[7] : 1'b0;
      end
    end
    scl_p = scl_n;
    sda_p = sda_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Counts rising iCLK edges after the GO edge until END is seen high.
  task automatic wait_end(output int cyc);
    cyc = 0;
    while (END !== 1'b1 && cyc < 1000) begin
      @(posedge iCLK);
      cyc++;
      @(negedge iCLK);
    end
  endtask

  task automatic launch(input logic wr, input logic [23:0] wd);
    @(negedge iCLK);
    WR = wr; WDATA = wd; GO = 1'b1;
    @(posedge iCLK);
    @(negedge iCLK);
    check("start_end_busy", {30'h0, END, BUSY}, 32'h1);
  endtask

  int cyc, s0, p0, b0, a0;

  initial begin : stimulus
    repeat (4) @(negedge iCLK);
    check("rst_scl",   I2C_SCLK, 1);
    check("rst_sda",   I2C_SDAT, 1);
    check("rst_end",   END, 1);
    check("rst_busy",  BUSY, 0);
    check("rst_ack",   ACK, 0);
    check("rst_rdata", RDATA, 8'h00);
    iRST_N = 1'b1;
    repeat (3) @(negedge iCLK);

    // 1: clean write
    s0 = starts; p0 = stops; b0 = bytes_q.size(); a0 = ack_q.size();
    launch(1'b1, 24'h42_12_80);
    wait_end(cyc);
    GO = 1'b0;
    check_range("t1_len", cyc, 230, 234);
    check("t1_b0", bytes_q[b0],   8'h42);
    check("t1_b1", bytes_q[b0+1], 8'h12);
    check("t1_b2", bytes_q[b0+2], 8'h80);
    check("t1_nbytes", bytes_q.size() - b0, 3);
    check("t1_ackslots", {ack_q[a0], ack_q[a0+1], ack_q[a0+2]}, 3'b000);
    check("t1_starts", starts - s0, 1);
    check("t1_stops",  stops - p0, 1);
    check("t1_ack",    ACK, 0);
    check("t1_rdata",  RDATA, 8'h00);
    check("t1_busy",   BUSY, 0);

    // 2: NACK on second byte, then a clean write clears ACK
    nack_mask = 4'b0010;
    s0 = starts; p0 = stops; b0 = bytes_q.size(); a0 = ack_q.size();
    launch(1'b1, 24'h42_3A_04);
    wait_end(cyc);
    GO = 1'b0;
    nack_mask = 4'b0000;
    check_range("t2_len", cyc, 230, 234);
    check("t2_b1", bytes_q[b0+1], 8'h3A);
    check("t2_b2", bytes_q[b0+2], 8'h04);
    check("t2_ackslots", {ack_q[a0], ack_q[a0+1], ack_q[a0+2]}, 3'b010);
    check("t2_stops", stops - p0, 1);
    check("t2_ack",   ACK, 1);
    launch(1'b1, 24'h42_3A_04);
    check("t2_ack_cleared", ACK, 0);
    wait_end(cyc);
    GO = 1'b0;
    check("t2_ack_again", ACK, 0);

    // 3: two-phase register read
    s0 = starts; p0 = stops; b0 = bytes_q.size(); a0 = ack_q.size();
    launch(1'b0, 24'h43_0A_00);
    wait_end(cyc);
    GO = 1'b0;
    check_range("t3_len", cyc, 318, 322);
    check("t3_b0", bytes_q[b0],   8'h42);
    check("t3_b1", bytes_q[b0+1], 8'h0A);
    check("t3_b2", bytes_q[b0+2], 8'h43);
    check("t3_b3", bytes_q[b0+3], 8'h76);
    check("t3_ackslots", {ack_q[a0], ack_q[a0+1], ack_q[a0+2], ack_q[a0+3]}, 4'b0001);
    check("t3_starts", starts - s0, 2);
    check("t3_stops",  stops - p0, 2);
    check("t3_rdata",  RDATA, 8'h76);
    check("t3_ack",    ACK, 0);

    // 4: GO held high and re-pulsed while busy gives one transaction only
    s0 = starts;
    launch(1'b1, 24'h42_55_AA);
    repeat (50) @(negedge iCLK);
    GO = 1'b0;
    repeat (3) @(negedge iCLK);
    GO = 1'b1;
    wait_end(cyc);
    check_range("t4_len", cyc, 176, 184);
    repeat (300) @(negedge iCLK);
    check("t4_one_txn", starts - s0, 1);
    check("t4_idle", {30'h0, END, BUSY}, 32'h2);
    check("t4_rdata_kept", RDATA, 8'h76);
    GO = 1'b0;
    @(negedge iCLK);
    GO = 1'b1;
    @(negedge iCLK);
    check("t4_restart_busy", BUSY, 1);
    wait_end(cyc);
    GO = 1'b0;
    check("t4_two_txn", starts - s0, 2);

    // 5: asynchronous reset in bit 3 of the second byte
    launch(1'b1, 24'h42_12_80);
    GO = 1'b0;
    repeat (104) @(posedge iCLK);
    #1 iRST_N = 1'b0;
    #1;
    check("t5_scl",   I2C_SCLK, 1);
    check("t5_sda",   I2C_SDAT, 1);
    check("t5_end",   END, 1);
    check("t5_busy",  BUSY, 0);
    check("t5_rdata", RDATA, 8'h00);
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;
    repeat (3) @(negedge iCLK);
    s0 = starts; p0 = stops; b0 = bytes_q.size();
    launch(1'b1, 24'h42_11_01);
    wait_end(cyc);
    GO = 1'b0;
    check_range("t5_len", cyc, 230, 234);
    check("t5_b1", bytes_q[b0+1], 8'h11);
    check("t5_b2", bytes_q[b0+2], 8'h01);
    check("t5_starts", starts - s0, 1);
    check("t5_stops",  stops - p0, 1);
    check("t5_ack",    ACK, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/sccb_master_engine.md
Name: sccb_master_engine

Overview:
- Bit-level SCCB/I2C master directly downstream of the configuration sequencer. The sequencer supplies a 24-bit word {slave_addr, reg_addr, data} plus GO/WR and waits on END/ACK.
- The engine generates START, the byte shifts, ACK sampling, and STOP on SCL/SDA. It also supports a two-phase register read, as required by OV7670/OV7725-class camera sensors.
- It generates its own quarter-bit timing from iCLK, so no external divided clock is needed.

Parameters:
CLK_FREQ, 25_000_000, iCLK frequency in Hz
I2C_FREQ, 100_000, SCL frequency in Hz
QTR, CLK_FREQ/(4*I2C_FREQ), iCLK cycles per quarter bit (floor); elaboration error if QTR < 2

Ports:
iCLK  in  1  system clock
iRST_N  in  1  asynchronous active-low reset
GO  in  1  start request; rising edge sampled in IDLE starts a transaction
WR  in  1  1 = 3-byte write, 0 = register read
WDATA  in  24  [23:16] slave address, [15:8] register address, [7:0] write data (ignored for read)
I2C_SCLK  out  1  SCL, push-pull, no clock stretching
I2C_SDAT  inout  1  SDA, open-drain: drives 0 or releases to z
END  out  1  1 = idle/finished, 0 = transaction in progress
ACK  out  1  1 = at least one slave NACK seen in last transaction
BUSY  out  1  inverse of END, registered
RDATA  out  8  byte returned by last read

Behaviour:
Reset and timing
- Reset values (asynchronous): I2C_SCLK=1, SDA released, END=1, ACK=0, BUSY=0, RDATA=8'h00, FSM=IDLE, counters 0.
- A free-running tick counter pulses every QTR cycles. The counter is cleared on transaction start, so the first quarter is aligned.
- Bit cell, 4 quarters: Q0 SCL=0 and SDA updated; Q1 SCL=0; Q2 SCL=1; Q3 SCL=1. SDA is sampled on the last cycle of Q2.
- START: SDA=1/SCL=1, then SDA=0 while SCL=1, then SCL=0.
- STOP: SCL=0/SDA=0, SCL=1, then SDA=1.
- START and STOP each take 4 quarters.
- SDA changes only while SCL=0, except in START and STOP.

Starting a transaction
- GO edge detect: start = GO & ~GO_d, evaluated only in IDLE. GO high or rising while BUSY is ignored.
- One cycle after start: END=0, BUSY=1, ACK cleared to 0.

FSM states
- IDLE, START, TX_BYTE, RX_ACK, STOP, RESTART_STOP, RESTART_START, RX_BYTE, TX_NACK, DONE.
- Bytes shift MSB first. A 3-bit bit counter runs 7→0.

Write (WR=1)
- Sequence: START, byte0={WDATA[23:17],0}, ack, WDATA[15:8], ack, WDATA[7:0], ack, STOP.
- Length: 116 quarters.

Read (WR=0)
- Phase 1: START, {WDATA[23:17],0}, ack, WDATA[15:8], ack, STOP.
- Phase 2: START, {WDATA[23:17],1}, ack, 8 bits received with SDA released, master NACK (SDA released during ack bit), STOP.
- Length: 160 quarters.
- RDATA is updated only at DONE of a read. Writes leave RDATA unchanged.

ACK handling
- ACK |= sampled SDA in each RX_ACK slot.
- A NACK does not abort; the transaction always completes. Fixed length simplifies retry in the sequencer.

Completion
- DONE lasts 1 cycle, then END=1 and BUSY=0 in the same cycle, then IDLE.
- END rises ≤2 cycles after the last STOP quarter ends. ACK and RDATA are valid when END rises and hold until the next start.

Reset mid-operation
- Immediate return to the reset values. The bus may be left mid-byte; the upstream retries.
- There is no bus-recovery sequence.

WR is latched at start; changes to WDATA and WR during BUSY are ignored.

Decomposition:
- Package sccb_pkg holds:
  - the FSM state enum
  - quarter-phase constants Q0..Q3
  - byte counts (WR_BYTES=3, RD_PH1_BYTES=2)
  - transaction lengths in quarters (116, 160)
- One sub-module, sccb_tick_gen: parameter QTR; inputs iCLK, iRST_N, clr; output tick; holds the quarter counter.
- The FSM, shift register, and SDA/SCL output registers stay in sccb_master_engine.

Test Plan:
Bench settings: CLK_FREQ=800, I2C_FREQ=100 (QTR=2). An SCCB slave model and a bus protocol checker run throughout; the checker flags any SDA change while SCL=1 outside START/STOP.
1. Write WR=1, WDATA=24'h42_12_80, slave ACKs all -> bus shows START, 0x42, 0x12, 0x80, STOP; END rises 232±2 cycles after GO edge; ACK=0.
2. Write 24'h42_3A_04, slave NACKs second byte -> full 116-quarter transaction, ACK=1 at END. Then a second write with all ACKs -> ACK=0.
3. Read WR=0, WDATA=24'h43_0A_00, slave returns 0x76 -> phase-1 byte 0x42 and 0x0A, STOP then START, phase-2 byte 0x43, SDA released in master ack slot; RDATA=8'h76, ACK=0, END after 320±2 cycles.
4. GO held high after END, plus a GO pulse mid-transaction -> exactly one transaction. The next transaction starts only after GO low→high.
5. iRST_N low during bit 3 of the second byte -> same cycle: I2C_SCLK=1, SDA=z, END=1, BUSY=0. After release, a write of 24'h42_11_01 completes cleanly with ACK=0.
